pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the fetch PC register and sequences instruction-memory requests.
- Turns the 2-bit jump select from the jump/branch decision logic into a fetch redirect, honouring MIPS delay-slot semantics: the instruction already fetched always issues.
- Sits between the hazard/stall logic, instruction memory and the ID/EX branch resolution point.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  datapath hazard; the fetched instruction must be held.
- jb_valid  in  1  one-cycle pulse: a branch/jump resolved this cycle.
- jump_sel  in  2  00 PC+4, 01 branch, 10 J/JAL, 11 JR/JALR; sampled only when jb_valid=1.
- branch_base  in  32  PC+4 of the branch instruction (the delay-slot address).
- imm_sext  in  32  sign-extended 16-bit immediate.
- jtarget  in  26  J-format target field.
- rs_val  in  32  register RS value for JR/JALR.
- imem_ack  in  1  instruction memory returns data for imem_addr this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to pc.
- pc  out  32  current fetch PC.
- inst_valid  out  1  the instruction at pc is available to decode.
- addr_err  out  1  one-cycle pulse: a redirect target was misaligned.
- redirect_cnt  out  32  taken-redirect counter (optional feature).

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, imem_req=0, inst_valid=0, addr_err=0, pending cleared, state=IDLE.
  - rst overrides everything, including mid-request; an outstanding ack is ignored.
- FSM states IDLE, WAIT, HOLD:
  - IDLE: imem_req=0. Next cycle goes to WAIT unconditionally, so the first request appears 1 cycle after rst deasserts.
  - WAIT: imem_req=1, imem_addr=pc.
    - imem_ack=1, stall=0: inst_valid=1 this cycle; pc<=next_pc; stay in WAIT.
    - imem_ack=1, stall=1: inst_valid=1; go to HOLD; pc unchanged.
    - imem_ack=0: inst_valid=0; stay in WAIT.
  - HOLD: imem_req=0, inst_valid=1. When stall=0: pc<=next_pc, go to WAIT.
- Target computation (combinational from the current inputs):
  - 01: branch_base + (imm_sext<<2), modulo 2^32.
  - 10: {branch_base[31:28], jtarget, 2'b00}.
  - 11: rs_val.
  - 00: no redirect. A jb_valid pulse with jump_sel=00 is ignored.
- Pending redirect:
  - A taken jb_valid in a cycle where pc does not advance latches pend_valid=1 and pend_target.
  - A new taken jb_valid while pending overwrites it (newest wins).
- next_pc priority:
  - (1) taken jb_valid this cycle → target.
  - (2) pend_valid → pend_target.
  - (3) pc+4, wrapping 32'hFFFF_FFFC → 0.
  - pend_valid clears on the edge where pc advances.
  - A taken jb_valid on the advancing edge is consumed directly and is never latched.
- Delay slot: the redirect takes effect on the pc advance after the one already in flight. The sequencer itself never squashes; the datapath asserts jb_valid during the delay-slot fetch.
- Misalignment:
  - Applies to a target with [1:0]≠00, possible only for 11.
  - Bits [1:0] are forced to 00, and addr_err pulses high for 1 cycle in the cycle jb_valid is sampled.
  - Latched pending targets are stored already aligned.
- Outputs are registered except inst_valid and imem_req, which are decoded from state and imem_ack.

Optional Feature:
- Macro: PC_SEQ_REDIRECT_STATS_EN.
- Defined: redirect_cnt is a 32-bit register.
  - Resets to 0.
  - Increments by 1 on every edge where pc is loaded from a redirect target (priority 1 or 2).
  - Wraps from 32'hFFFF_FFFF to 0.
- Undefined: redirect_cnt is tied to 32'h0 and no counter logic is built; the port list is unchanged.

Test Plan:
- Reset release with RESET_PC=32'h0040_0000, imem_ack held 1 → imem_req rises 1 cycle after rst falls; pc sequence 0x400000, 0x400004, 0x400008.
- At pc=0x400010, jb_valid with jump_sel=01, branch_base=0x40000C, imem_sext=32'hFFFF_FFFD → next pc=0x400000; redirect_cnt increments by 1.
- stall=1 for 3 cycles on ack; jb_valid with jump_sel=10, jtarget=26'h000_0100, branch_base=0x4000_0020 during the stall → held in HOLD with inst_valid=1; on stall release pc=0x4000_0400.
- imem_ack=0 for 4 cycles, jump_sel=11 with rs_val=0x1000_0006 → addr_err pulses once; after ack pc=0x1000_0004.
- rst asserted in WAIT with pend_valid=1 → next cycle pc=RESET_PC, imem_req=0, pending cleared, redirect_cnt=0.
- pc=32'hFFFF_FFFC with no redirect, ack=1 → pc wraps to 32'h0000_0000.

Source files
------------

// File: rtl/pc_sequencer.sv
//==============================================================================
// Module  : pc_sequencer
// Brief   : Fetch PC owner and instruction-memory request sequencer with
//           MIPS delay-slot redirect handling. Optional redirect counter is
//           built when PC_SEQ_REDIRECT_STATS_EN is defined.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb_valid,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] branch_base,
  input  logic [31:0] imm_sext,
  input  logic [25:0] jtarget,
  input  logic [31:0] rs_val,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        inst_valid,
  output logic        addr_err,
  output logic [31:0] redirect_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] raw_target;
  logic [31:0] target;
  logic        taken;
  logic        advance;
  logic [31:0] next_pc;

  always_comb begin
    case (jump_sel)
      2'b01:   raw_target = branch_base + (imm_sext << 2);
      2'b10:   raw_target = {branch_base[31:28], jtarget, 2'b00};
      2'b11:   raw_target = rs_val;
      default: raw_target = pc_q + 32'd4;
    endcase
  end

  assign taken  = jb_valid && (jump_sel != 2'b00);
  assign target = {raw_target[31:2], 2'b00};

  assign imem_req   = (state_q == ST_WAIT);
  assign inst_valid = ((state_q == ST_WAIT) && imem_ack) || (state_q == ST_HOLD);
  assign advance    = !stall && (((state_q == ST_WAIT) && imem_ack) || (state_q == ST_HOLD));

  // A redirect seen this cycle beats an older pending one (newest wins).
  assign next_pc = taken        ? target        :
                   pend_valid_q ? pend_target_q :
                                  pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    addr_err_d    = taken && (raw_target[1:0] != 2'b00);

    case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: if (imem_ack && stall) state_d = ST_HOLD;
      ST_HOLD: if (!stall) state_d = ST_WAIT;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
    end else if (taken) begin
      pend_valid_d  = 1'b1;
      pend_target_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign addr_err  = addr_err_q;

`ifdef PC_SEQ_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic        redirect_load;

  assign redirect_load = advance && (taken || pend_valid_q);

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    if (redirect_load) redirect_cnt_d = redirect_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) redirect_cnt_q <= 32'h0000_0000;
    else     redirect_cnt_q <= redirect_cnt_d;
  end

  assign redirect_cnt = redirect_cnt_q;
`else
  assign redirect_cnt = 32'h0000_0000;
`endif

endmodule

`default_nettype wire
